chan_sel_mux: RTL
=================

Name: chan_sel_mux

Overview:
- Parametrised N:1 channel selector with a registered output stage and valid/ready handshakes on every input channel and on the output.
- Two modes:
  - Direct select: the channel index is driven by `sel`.
  - Round-robin scan: the block picks the next valid channel itself.
- Out-of-range select values are flagged, never silently mapped.
- Sits between peripheral/status sources and a single downstream consumer in the processor datapath.

Parameters:
- NUM_CH, 10, number of input channels (2..16)
- DATA_W, 1, width of each channel's data
- SEL_W, 4, width of `sel`/`out_ch`; must satisfy 2^SEL_W >= NUM_CH

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  NUM_CH*DATA_W  flattened channel data; channel i occupies bits [i*DATA_W +: DATA_W]
- in_valid  input  NUM_CH  per-channel valid
- in_ready  output  NUM_CH  per-channel ready (one-hot or zero)
- mode  input  1  0 = direct select, 1 = round-robin
- sel  input  SEL_W  channel index, used in direct mode only
- out_data  output  DATA_W  registered selected data
- out_ch  output  SEL_W  index of the channel held in out_data
- out_valid  output  1  output register holds data
- out_ready  input  1  downstream accepts
- sel_err  output  1  one-cycle pulse: invalid select observed

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_ch=0, sel_err=0.
  - rr_ptr=NUM_CH-1, so the first scan starts at channel 0.
- load_en = !out_valid || out_ready. There is one output entry, and the block gives full throughput when the downstream holds out_ready=1.
- Direct mode (mode=0):
  - cand = sel.
  - If sel < NUM_CH and load_en: in_ready[sel]=1; all other in_ready=0.
  - If additionally in_valid[sel]=1, then on the next edge out_data<=channel sel, out_ch<=sel, out_valid<=1.
  - If sel >= NUM_CH: all in_ready=0, and no load occurs.
  - sel_err <= 1 for exactly the cycle following each cycle in which mode=0, load_en=1 and sel >= NUM_CH. Otherwise sel_err <= 0. The output register is untouched.
- Round-robin mode (mode=1):
  - cand = first i with in_valid[i]=1, searching (rr_ptr+1) mod NUM_CH upward with wrap.
  - If one is found and load_en: in_ready[cand]=1; load as in direct mode; rr_ptr<=cand.
  - If none is valid: in_ready all 0; rr_ptr holds.
  - sel is ignored and sel_err stays 0.
- If load_en=1 but no transfer occurs, out_valid<=0 on that edge (the held data is consumed). out_data and out_ch hold their last values.
- If load_en=0, all in_ready=0. out_data, out_ch and out_valid hold, so output is stable while stalled.
- in_ready depends combinationally on mode, sel, in_valid (round-robin only) and out_ready. There is no combinational path from in_data to out_data.
- Mode change:
  - Takes effect the same cycle for cand.
  - rr_ptr is retained across direct-mode periods.
  - rr_ptr is updated only by round-robin grants.
- Latency: one cycle from an input handshake to out_valid.
- Reset mid-transfer: the output entry is discarded; out_valid=0 immediately.

Decomposition:
- Shared package chan_sel_pkg:
  - MODE_DIRECT=1'b0, MODE_RR=1'b1.
  - Function computing the minimum SEL_W for a given NUM_CH, used for elaboration checks.
- Sub-module rr_pick: combinational round-robin finder.
  - Parameter NUM_CH.
  - Inputs: req[NUM_CH], ptr.
  - Outputs: found, idx.
  - Uses a double-width masked priority search.

Test Plan:
- Direct mode, defaults, out_ready=1: sel=3, in_data=10'b0000001000 (only ch3 set), in_valid[3]=1 -> next cycle out_data=1, out_ch=3, out_valid=1, in_ready=10'b0000001000.
- Direct mode, sel=12 (NUM_CH=10), out_ready=1 -> in_ready=0, out_valid drops to 0, sel_err=1 for one cycle; with sel held at 12, sel_err stays 1 each cycle.
- Back-pressure: out_valid=1, out_ready=0 for 5 cycles with sel toggling 0..4 -> out_data and out_ch frozen, in_ready=0 throughout; release out_ready -> next channel loaded on the following edge.
- Round-robin, in_valid=10'b1000100101, out_ready=1 -> grant order 0,2,5,9,0,2,... with out_ch following one cycle later and no channel skipped.
- Round-robin wrap and idle: rr_ptr=9 and in_valid=0 -> no grant, rr_ptr stays 9; then in_valid[9] and in_valid[1] set -> grant 1, then 9.
- Reset asserted while out_valid=1 with round-robin active -> out_valid, out_data, sel_err all 0 asynchronously; after release, first round-robin grant goes to the lowest valid channel.

Source files
------------

// File: rtl/chan_sel_pkg.sv
// Shared definitions for the channel selector: mode encodings and the
// select-width helper used by the elaboration-time parameter checks.
package chan_sel_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Smallest select width able to address n channels.
    function automatic int min_sel_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: returns the first requesting index
// strictly after ptr, wrapping around, via a double-width masked search.
module rr_pick #(
    parameter int NUM_CH = 10,
    parameter int PTR_W  = 4
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic              found,
    output logic [PTR_W-1:0]  idx
);

    logic [2*NUM_CH-1:0] dbl;
    logic [2*NUM_CH-1:0] masked;

    // Upper copy of req covers the wrapped part of the search window.
    always_comb begin
        dbl    = {req, req};
        masked = '0;
        for (int j = 0; j < 2*NUM_CH; j++) begin
            masked[j] = dbl[j] && (j > int'(ptr));
        end
        found = 1'b0;
        idx   = '0;
        for (int j = 2*NUM_CH-1; j >= 0; j--) begin
            if (masked[j]) begin
                found = 1'b1;
                idx   = PTR_W'((j >= NUM_CH) ? (j - NUM_CH) : j);
            end
        end
    end

endmodule

// File: rtl/chan_sel_mux.sv
// N:1 channel selector with one registered output entry, direct or
// round-robin channel choice, and a pulse flag for out-of-range selects.
module chan_sel_mux
    import chan_sel_pkg::*;
#(
    parameter int NUM_CH = 10,
    parameter int DATA_W = 1,
    parameter int SEL_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sel_err
);

    if (NUM_CH < 2 || NUM_CH > 16) begin : g_bad_num_ch
        $error("chan_sel_mux: NUM_CH must be within 2..16");
    end
    if (SEL_W < min_sel_w(NUM_CH)) begin : g_bad_sel_w
        $error("chan_sel_mux: SEL_W too narrow for NUM_CH");
    end

    logic [SEL_W-1:0]  rr_ptr;
    logic              rr_found;
    logic [SEL_W-1:0]  rr_idx;
    logic              load_en;
    logic              sel_ok;
    logic [SEL_W-1:0]  cand;
    logic              cand_ok;
    logic              cand_valid;
    logic [DATA_W-1:0] cand_data;
    logic              grant;
    logic              xfer;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .PTR_W  (SEL_W)
    ) u_rr_pick (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .found (rr_found),
        .idx   (rr_idx)
    );

    assign load_en = !out_valid || out_ready;
    assign sel_ok  = int'(sel) < NUM_CH;

    // Candidate choice; data/valid are picked by index compare so an
    // out-of-range sel never indexes past the flattened bus.
    always_comb begin
        cand       = sel;
        cand_ok    = sel_ok;
        cand_valid = 1'b0;
        cand_data  = '0;
        in_ready   = '0;
        if (mode == MODE_RR) begin
            cand    = rr_idx;
            cand_ok = rr_found;
        end
        grant = load_en && cand_ok;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(cand) == i) begin
                cand_valid  = in_valid[i];
                cand_data   = in_data[i*DATA_W +: DATA_W];
                in_ready[i] = grant;
            end
        end
        xfer = grant && cand_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            sel_err   <= 1'b0;
            rr_ptr    <= SEL_W'(NUM_CH - 1);
        end else begin
            sel_err <= (mode == MODE_DIRECT) && load_en && !sel_ok;
            if (load_en) begin
                // A free slot with no transfer means the held entry was consumed.
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= cand_data;
                    out_ch   <= cand;
                end
            end
            if (mode == MODE_RR && xfer) begin
                rr_ptr <= cand;
            end
        end
    end

endmodule
